local_store_pipe: RTL and testbench

- Parametrised next-generation SPU local-store unit (odd pipe).
- Decodes the six quadword load/store instructions, computes aligned local-store addresses and owns the single-ported local-store array.
- Returns load data to the WB stage after a fixed, parametrised latency.
- Sits between the RF/FWD stage and WB, alongside the other execution pipes.

---
 rtl/ls_pkg.sv | 30 +++
 rtl/ls_delay_line.sv | 30 +++
 rtl/local_store_pipe.sv | 179 +++++++++++++++++
 tb/tb_local_store_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// ls_pkg: shared opcodes, instruction formats, quadword type and the
// local-store address helper used by the local-store pipe.
package ls_pkg;

  localparam int unsigned QW_BITS = 128;

  typedef logic [0:QW_BITS-1] qw_t;

  typedef enum logic [2:0] {
    FMT_RR   = 3'd0,
    FMT_RI10 = 3'd1,
    FMT_RI16 = 3'd2
  } fmt_e;

  // Opcodes are left-aligned in the 11-bit op field.
  localparam logic [0:10] OP_LQX  = 11'b00111000100;
  localparam logic [0:7]  OP_LQD  = 8'b00110100;
  localparam logic [0:8]  OP_LQA  = 9'b001100001;
  localparam logic [0:10] OP_STQX = 11'b00101000100;
  localparam logic [0:7]  OP_STQD = 8'b00100100;
  localparam logic [0:8]  OP_STQA = 9'b001000001;

  // 32-bit wrapping add, limit to the local store, then quadword-align.
  function automatic logic [31:0] ls_addr(input logic [31:0] base,
                                          input logic [31:0] offs,
                                          input logic [31:0] lslr);
    return (base + offs) & lslr & ~32'hF;
  endfunction

endpackage

// File: rtl/ls_delay_line.sv
// ls_delay_line: synchronous-reset shift register of DEPTH stages, WIDTH bits each.
module ls_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift the bundle one stage per cycle; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/local_store_pipe.sv
// local_store_pipe: SPU odd-pipe local-store unit. Decodes the quadword
// load/store instructions, owns the single-ported local-store array and
// returns load data to WB after LAT cycles.
// Optional MFC-side DMA port: define LS_DMA_PORT_EN.
module local_store_pipe
  import ls_pkg::*;
#(
  parameter int unsigned LS_BYTES = 32768,
  parameter int unsigned QW_BITS  = 128,
  parameter int unsigned LAT      = 6,
  parameter int unsigned ADDR_W   = $clog2(LS_BYTES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [0:10]          op,
  input  logic [2:0]           format,
  input  logic [0:6]           rt_addr,
  input  logic [0:QW_BITS-1]   ra,
  input  logic [0:QW_BITS-1]   rb,
  input  logic [0:QW_BITS-1]   rt_st,
  input  logic [0:17]          imm,
  input  logic                 reg_write,
`ifdef LS_DMA_PORT_EN
  input  logic                 dma_valid,
  output logic                 dma_ready,
  input  logic                 dma_we,
  input  logic [ADDR_W-1:0]    dma_addr,
  input  logic [0:QW_BITS-1]   dma_wdata,
  output logic [0:QW_BITS-1]   dma_rdata,
  output logic                 dma_rvalid,
`endif
  output logic [0:QW_BITS-1]   rt_wb,
  output logic [0:6]           rt_addr_wb,
  output logic                 reg_write_wb
);

  localparam int unsigned IDX_W = ADDR_W - 4;
  localparam int unsigned NQW   = LS_BYTES / 16;
  localparam logic [31:0] LSLR  = 32'(LS_BYTES - 1);

  logic [31:0]      ra_w;
  logic [31:0]      rb_w;
  logic [31:0]      sext10;
  logic [31:0]      sext16;
  logic [31:0]      base;
  logic [31:0]      offs;
  logic [31:0]      addr32;
  logic [IDX_W-1:0] idx;
  logic             is_load;
  logic             is_store;

  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [IDX_W-1:0] mem_ridx;
  qw_t              mem_wdata;
  qw_t              mem_q [NQW];

  qw_t              s1_rt_q;
  logic [0:6]       s1_addr_q;
  logic             s1_we_q;

  // Preferred-slot words and scaled, sign-extended immediates.
  assign ra_w   = ra[0:31];
  assign rb_w   = rb[0:31];
  assign sext10 = {{18{imm[8]}}, imm[8:17], 4'b0000};
  assign sext16 = {{14{imm[2]}}, imm[2:17], 2'b00};

  // Decode the six load/store forms and select the address operands.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    base     = '0;
    offs     = '0;
    case (format)
      FMT_RR: begin
        base     = ra_w;
        offs     = rb_w;
        is_load  = (op == OP_LQX);
        is_store = (op == OP_STQX);
      end
      FMT_RI10: begin
        base     = ra_w;
        offs     = sext10;
        is_load  = (op[0:7] == OP_LQD);
        is_store = (op[0:7] == OP_STQD);
      end
      FMT_RI16: begin
        base     = '0;
        offs     = sext16;
        is_load  = (op[0:8] == OP_LQA);
        is_store = (op[0:8] == OP_STQA);
      end
      default: begin
        is_load  = 1'b0;
        is_store = 1'b0;
      end
    endcase
  end

  assign addr32 = ls_addr(base, offs, LSLR);
  assign idx    = addr32[ADDR_W-1:4];

`ifdef LS_DMA_PORT_EN
  logic             dma_xfer;
  logic [IDX_W-1:0] dma_idx;
  qw_t              dma_rdata_q;
  logic             dma_rvalid_q;

  // The SPU owns the single port whenever it issues a load or store.
  assign dma_ready = ~(is_load | is_store);
  assign dma_xfer  = dma_valid & dma_ready;
  assign dma_idx   = dma_addr[ADDR_W-1:4];

  assign mem_we    = (is_store & ~reset) | (dma_xfer & dma_we);
  assign mem_widx  = is_store ? idx : dma_idx;
  assign mem_wdata = is_store ? rt_st : dma_wdata;
  assign mem_ridx  = is_load ? idx : dma_idx;

  // DMA read data returns one cycle after the accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      dma_rvalid_q <= dma_xfer & ~dma_we;
      if (dma_xfer && !dma_we) begin
        dma_rdata_q <= mem_q[mem_ridx];
      end
    end
  end

  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;

  logic unused_ok;
  assign unused_ok = ^{ra[32:QW_BITS-1], rb[32:QW_BITS-1], imm[0:1],
                       addr32[31:ADDR_W], addr32[3:0], dma_addr[3:0]};
`else
  assign mem_we    = is_store & ~reset;
  assign mem_widx  = idx;
  assign mem_wdata = rt_st;
  assign mem_ridx  = idx;

  logic unused_ok;
  assign unused_ok = ^{ra[32:QW_BITS-1], rb[32:QW_BITS-1], imm[0:1],
                       addr32[31:ADDR_W], addr32[3:0]};
`endif

  // Single write port into the local-store array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  // Stage 1: synchronous array read for loads; everything else is a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_rt_q   <= '0;
      s1_addr_q <= '0;
      s1_we_q   <= 1'b0;
    end else begin
      s1_rt_q   <= is_load ? mem_q[mem_ridx] : '0;
      s1_addr_q <= is_load ? rt_addr : '0;
      s1_we_q   <= is_load & reg_write;
    end
  end

  ls_delay_line #(
    .WIDTH (QW_BITS + 8),
    .DEPTH (LAT - 1)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .d_i   ({s1_rt_q, s1_addr_q, s1_we_q}),
    .q_o   ({rt_wb, rt_addr_wb, reg_write_wb})
  );

endmodule

// File: tb/tb_local_store_pipe.sv
// tb_local_store_pipe: random and directed stimulus against a cycle-keyed
// behavioural model of the local-store pipe.
module tb_local_store_pipe;

  localparam int unsigned LS_BYTES = 32768;
  localparam int unsigned LAT      = 6;
  localparam int unsigned NQW      = LS_BYTES / 16;

  localparam logic [127:0] LIT1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] LIT2 = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
  localparam logic [127:0] LIT3 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] LIT4 = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;
  localparam logic [127:0] LITA = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;

  logic         clk = 1'b0;
  logic         reset;
  logic [10:0]  op;
  logic [2:0]   format;
  logic [6:0]   rt_addr;
  logic [127:0] ra, rb, rt_st;
  logic [17:0]  imm;
  logic         reg_write;
  logic [127:0] rt_wb;
  logic [6:0]   rt_addr_wb;
  logic         reg_write_wb;
`ifdef LS_DMA_PORT_EN
  logic         dma_valid, dma_ready, dma_we, dma_rvalid;
  logic [14:0]  dma_addr;
  logic [127:0] dma_wdata, dma_rdata;
  logic         last_ready;
`endif

  always #5 clk = ~clk;

  local_store_pipe #(
    .LS_BYTES (LS_BYTES),
    .QW_BITS  (128),
    .LAT      (LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .format       (format),
    .rt_addr      (rt_addr),
    .ra           (ra),
    .rb           (rb),
    .rt_st        (rt_st),
    .imm          (imm),
    .reg_write    (reg_write),
`ifdef LS_DMA_PORT_EN
    .dma_valid    (dma_valid),
    .dma_ready    (dma_ready),
    .dma_we       (dma_we),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .dma_rdata    (dma_rdata),
    .dma_rvalid   (dma_rvalid),
`endif
    .rt_wb        (rt_wb),
    .rt_addr_wb   (rt_addr_wb),
    .reg_write_wb (reg_write_wb)
  );

  typedef struct {
    logic [127:0] data;
    logic [6:0]   rta;
    logic         rw;
  } wb_t;

  logic [127:0] model_mem [NQW];
  wb_t          exp_wb [int];
  wb_t          lit_wb [int];
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic void chk(input string nm, input logic [127:0] act,
                              input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, req);
    end
  endfunction

  // kind: 0 = bubble, 1 = load, 2 = store; qidx = quadword index touched.
  function automatic void m_decode(input logic [2:0] f, input logic [10:0] o,
                                   input logic [127:0] a, input logic [127:0] b,
                                   input logic [17:0] im,
                                   output int kind, output int unsigned qidx);
    int unsigned ea;
    int v;
    ea   = 0;
    kind = 0;
    if (f == 3'd0) begin
      ea = a[127:96] + b[127:96];
      if (o == 11'b00111000100) kind = 1;
      else if (o == 11'b00101000100) kind = 2;
    end else if (f == 3'd1) begin
      v = int'(im[9:0]);
      if (v >= 512) v = v - 1024;
      ea = a[127:96] + unsigned'(v * 16);
      if (o[10:3] == 8'b00110100) kind = 1;
      else if (o[10:3] == 8'b00100100) kind = 2;
    end else if (f == 3'd2) begin
      v = int'(im[15:0]);
      if (v >= 32768) v = v - 65536;
      ea = unsigned'(v * 4);
      if (o[10:2] == 9'b001100001) kind = 1;
      else if (o[10:2] == 9'b001000001) kind = 2;
    end
    qidx = (ea % LS_BYTES) / 16;
  endfunction

  // Drive one instruction for the current cycle and update the model.
  task automatic issue(input logic [2:0] f, input logic [10:0] o,
                       input logic [6:0] rta, input logic [127:0] a,
                       input logic [127:0] b, input logic [127:0] st,
                       input logic [17:0] im, input logic rw, input logic rst);
    int kind;
    int unsigned q;
    int ks[$];
    format = f; op = o; rt_addr = rta; ra = a; rb = b;
    rt_st = st; imm = im; reg_write = rw; reset = rst;
    m_decode(f, o, a, b, im, kind, q);
    if (rst) begin
      foreach (exp_wb[k]) if (k > cyc) ks.push_back(k);
      foreach (ks[i]) exp_wb.delete(ks[i]);
    end else if (kind == 1) begin
      exp_wb[cyc + LAT] = '{model_mem[q], rta, rw};
    end else if (kind == 2) begin
      model_mem[q] = st;
    end
`ifdef LS_DMA_PORT_EN
    #1 last_ready = dma_ready;
`endif
    @(negedge clk);
  endtask

  task automatic nop();
    issue(3'd0, 11'd0, 7'd0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // Every cycle after the first reset edge, WB outputs must match the model.
  always @(negedge clk) begin
    wb_t e;
    if (cyc >= 1) begin
      if (exp_wb.exists(cyc)) e = exp_wb[cyc];
      else e = '{'0, '0, 1'b0};
      chk("rt_wb", rt_wb, e.data);
      chk("rt_addr_wb", {121'd0, rt_addr_wb}, {121'd0, e.rta});
      chk("reg_write_wb", {127'd0, reg_write_wb}, {127'd0, e.rw});
      if (lit_wb.exists(cyc)) begin
        chk("lit_rt_wb", rt_wb, lit_wb[cyc].data);
        chk("lit_rt_addr_wb", {121'd0, rt_addr_wb}, {121'd0, lit_wb[cyc].rta});
        chk("lit_reg_write_wb", {127'd0, reg_write_wb}, {127'd0, lit_wb[cyc].rw});
      end
    end
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int r, rsel;
    logic [2:0]  f;
    logic [10:0] o;
`ifdef LS_DMA_PORT_EN
    dma_valid = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
`endif
    issue(3'd0, 11'd0, 7'd0, '0, '0, '0, '0, 1'b0, 1'b1);
    issue(3'd0, 11'd0, 7'd0, '0, '0, '0, '0, 1'b0, 1'b1);
`ifdef LS_DMA_PORT_EN
    chk("dma_rvalid_reset", {127'd0, dma_rvalid}, 128'd0);
    chk("dma_rdata_reset", dma_rdata, 128'd0);
`endif

    // Preload the whole store so every later load has defined data.
    for (int i = 0; i < int'(NQW); i++) begin
      issue(3'd2, {9'b001000001, 2'b00}, 7'd0, '0, '0,
            {$urandom, $urandom, $urandom, $urandom}, 18'(i * 4), 1'b1, 1'b0);
    end

    // stqa 0x40 then lqa 0x40 back-to-back.
    issue(3'd2, {9'b001000001, 2'b00}, 7'd0, '0, '0, LIT1, 18'h00010, 1'b1, 1'b0);
    lit_wb[cyc + LAT] = '{LIT1, 7'd5, 1'b1};
    issue(3'd2, {9'b001100001, 2'b00}, 7'd5, '0, '0, '0, 18'h00010, 1'b1, 1'b0);

    // stqd with negative I10, then lqx to an unaligned address of the same quadword.
    issue(3'd1, {8'b00100100, 3'b000}, 7'd0, {32'h00003FF5, 96'd0}, '0, LIT2,
          18'h003FF, 1'b0, 1'b0);
    lit_wb[cyc + LAT] = '{LIT2, 7'd9, 1'b1};
    issue(3'd0, 11'b00111000100, 7'd9, {32'h00003FE7, 96'd0}, '0, '0, '0, 1'b1, 1'b0);

    // Address beyond the store wraps through LSLR.
    issue(3'd2, {9'b001000001, 2'b11}, 7'd0, '0, '0, LIT3, 18'h00004, 1'b0, 1'b0);
    lit_wb[cyc + LAT] = '{LIT3, 7'd17, 1'b0};
    issue(3'd0, 11'b00111000100, 7'd17, {32'h00008010, 96'd0}, '0, '0, '0, 1'b0, 1'b0);

    // Ten back-to-back lqd to distinct quadwords.
    for (int k = 0; k < 10; k++) begin
      issue(3'd1, {8'b00110100, 3'b101}, 7'(k + 20), {32'(32'h1000 + k * 64), 96'd0},
            '0, '0, 18'(k), 1'b1, 1'b0);
    end

    // Load, then reset two cycles later: it must never reach WB; a store
    // issued under reset must not land.
    issue(3'd2, {9'b001100001, 2'b00}, 7'd7, '0, '0, '0, 18'h00010, 1'b1, 1'b0);
    nop();
    for (int k = 1; k <= int'(LAT); k++) lit_wb[cyc + k] = '{'0, 7'd0, 1'b0};
    issue(3'd2, {9'b001000001, 2'b00}, 7'd0, '0, '0, ~LIT1, 18'h00010, 1'b1, 1'b1);
    nop();
    lit_wb[cyc + LAT] = '{LIT1, 7'd11, 1'b1};
    issue(3'd2, {9'b001100001, 2'b00}, 7'd11, '0, '0, '0, 18'h00010, 1'b1, 1'b0);

`ifdef LS_DMA_PORT_EN
    // DMA write while the SPU idles.
    dma_valid = 1'b1; dma_we = 1'b1; dma_addr = 15'h0100; dma_wdata = LITA;
    nop();
    chk("dma_ready_idle", {127'd0, last_ready}, 128'd1);
    model_mem[16] = LITA;
    // DMA write colliding with an SPU store is refused.
    dma_addr = 15'h0200; dma_wdata = LIT4;
    issue(3'd2, {9'b001000001, 2'b00}, 7'd0, '0, '0, LIT4, 18'h000C0, 1'b0, 1'b0);
    chk("dma_ready_busy", {127'd0, last_ready}, 128'd0);
    dma_valid = 1'b0; dma_we = 1'b0;
    lit_wb[cyc + LAT] = '{LITA, 7'd3, 1'b1};
    issue(3'd2, {9'b001100001, 2'b00}, 7'd3, '0, '0, '0, 18'h00040, 1'b1, 1'b0);
    issue(3'd2, {9'b001100001, 2'b00}, 7'd4, '0, '0, '0, 18'h00080, 1'b1, 1'b0);
    // DMA read with low address bits set.
    dma_valid = 1'b1; dma_we = 1'b0; dma_addr = 15'h0107;
    nop();
    dma_valid = 1'b0;
    chk("dma_rvalid", {127'd0, dma_rvalid}, 128'd1);
    chk("dma_rdata", dma_rdata, LITA);
    nop();
    chk("dma_rvalid_drop", {127'd0, dma_rvalid}, 128'd0);
`endif

    // Random mix of valid, mangled and invalid instructions with rare resets.
    for (int n = 0; n < 3000; n++) begin
      rsel = $urandom_range(0, 7);
      o = 11'($urandom);
      case (rsel)
        0: begin f = 3'd0; o = 11'b00111000100; end
        1: begin f = 3'd1; o = {8'b00110100, o[2:0]}; end
        2: begin f = 3'd2; o = {9'b001100001, o[1:0]}; end
        3: begin f = 3'd0; o = 11'b00101000100; end
        4: begin f = 3'd1; o = {8'b00100100, o[2:0]}; end
        5: begin f = 3'd2; o = {9'b001000001, o[1:0]}; end
        default: f = 3'($urandom_range(0, 2));
      endcase
      r = $urandom_range(0, 99);
      if (r < 8) f = 3'($urandom_range(3, 7));
      issue(f, o, 7'($urandom), {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom},
            18'($urandom), 1'($urandom), (r == 99));
    end

    for (int k = 0; k < int'(LAT) + 2; k++) nop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
